// File: rtl/pixel_scanout.sv
// Raster timing generator and pixel scan-out: HOLD/ARM/RUN sequencer driving
// h/v counters, source read requests, and delay-aligned sync/de/rgb outputs.
module pixel_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_LAT  = 1,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_src_rst,
  input  logic [23:0] i_pixel,
  output logic        o_rd,
  output logic        o_newline,
  output logic        o_newframe,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [23:0] o_rgb,
  output logic [7:0]  o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare count of headroom so sync-end constants equal to the total still fit.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_HOLD, S_ARM, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_run;
  logic            w_cnt_en;
  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic [7:0]      r_frame_cnt;
  logic            w_h_last;
  logic            w_v_last;
  logic            w_de_raw;
  logic            w_hs_raw;
  logic            w_vs_raw;
  logic [2:0]      r_pipe [PIX_LAT];
  logic            r_de;
  logic            r_hs;
  logic            r_vs;
  logic [23:0]     r_rgb;
  logic            w_tap_de;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_HOLD;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_HOLD:  if (!i_src_rst) w_state_next = S_ARM;
      S_ARM:   w_state_next = S_RUN;
      S_RUN:   if (i_src_rst) w_state_next = S_HOLD;
      default: w_state_next = S_HOLD;
    endcase
  end

  always_comb begin
    w_run    = (r_state == S_RUN);
    w_cnt_en = (r_state == S_RUN) && !i_src_rst;
  end

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // Counters only advance in an uninterrupted RUN; any other clock parks them at 0.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
    end else if (w_cnt_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        if (w_v_last) r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end else begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end
  end

  assign w_de_raw   = w_run && (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_raw   = w_run && (r_h_cnt >= H_SS) && (r_h_cnt < H_SE);
  assign w_vs_raw   = w_run && (r_v_cnt >= V_SS) && (r_v_cnt < V_SE);
  assign o_rd       = w_de_raw;
  assign o_newframe = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_newline  = w_run && (r_h_cnt == '0) && (r_v_cnt != '0);

  // Timing bits travel active-high; polarity is applied only at the pins.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PIX_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {w_de_raw, w_hs_raw, w_vs_raw};
      for (int i = 1; i < PIX_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_tap_de = r_pipe[PIX_LAT-1][2];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_de  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_de  <= w_tap_de;
      r_hs  <= r_pipe[PIX_LAT-1][1];
      r_vs  <= r_pipe[PIX_LAT-1][0];
      r_rgb <= w_tap_de ? i_pixel : 24'd0;
    end
  end

  assign o_de        = r_de;
  assign o_rgb       = r_rgb;
  assign o_hsync     = (SYNC_POL != 0) ? r_hs : ~r_hs;
  assign o_vsync     = (SYNC_POL != 0) ? r_vs : ~r_vs;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_pixel_scanout.sv
// Directed bench for pixel_scanout on a small raster (15x8 clocks/lines, PIX_LAT=2).
module tb_pixel_scanout;

  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 4;
  localparam int PIX_LAT  = 2;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_src_rst;
  logic [23:0] i_pixel;
  logic        o_rd, o_newline, o_newframe, o_hsync, o_vsync, o_de;
  logic [23:0] o_rgb;
  logic [7:0]  o_frame_cnt;

  pixel_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(V_ACTIVE), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_LAT(PIX_LAT), .SYNC_POL(0)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_src_rst(i_src_rst), .i_pixel(i_pixel),
    .o_rd(o_rd), .o_newline(o_newline), .o_newframe(o_newframe),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_rgb(o_rgb),
    .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  // Pixel source: pattern {x, y, 5A}, returned PIX_LAT clocks after o_rd.
  logic [7:0]  sx, sy;
  logic [23:0] d1, d2;
  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sx <= 8'd0; sy <= 8'd0; d1 <= 24'hDEAD00; d2 <= 24'hDEAD00;
    end else begin
      d2 <= d1;
      if (o_newframe) begin
        d1 <= 24'h00005A; sx <= 8'd1; sy <= 8'd0;
      end else if (o_rd) begin
        d1 <= {sx, sy, 8'h5A};
        if (sx == 8'(H_ACTIVE - 1)) begin
          sx <= 8'd0;
          sy <= (sy == 8'(V_ACTIVE - 1)) ? 8'd0 : sy + 8'd1;
        end else begin
          sx <= sx + 8'd1;
        end
      end else begin
        d1 <= 24'hDEAD00;
      end
    end
  end
  assign i_pixel = d2;

  typedef struct {
    string      name;
    int         cyc;
    logic       rd, nl, nf, de, hs, vs;
    logic [23:0] rgb;
    logic [7:0]  fc;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;
  int c     = 0;
  int n_rd = 0, n_nl = 0, n_nf = 0, n_hs = 0, n_vs = 0, n_both = 0, n_hold_strobe = 0;

  function automatic void add(string name, int cyc, logic rd, logic nl, logic nf,
                              logic de, logic hs, logic vs, logic [23:0] rgb, logic [7:0] fc);
    vec_t v;
    v.name = name; v.cyc = cyc; v.rd = rd; v.nl = nl; v.nf = nf;
    v.de = de; v.hs = hs; v.vs = vs; v.rgb = rgb; v.fc = fc;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, c);
    end else begin
      $display("check %s ok: %0h", name, act);
    end
  endtask

  task automatic chk_vec(vec_t v);
    logic [37:0] got, exp;
    got = {o_rd, o_newline, o_newframe, o_de, o_hsync, o_vsync, o_rgb, o_frame_cnt};
    exp = {v.rd, v.nl, v.nf, v.de, v.hs, v.vs, v.rgb, v.fc};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s c=%0d: got rd=%b nl=%b nf=%b de=%b hs=%b vs=%b rgb=%h fc=%0d expected rd=%b nl=%b nf=%b de=%b hs=%b vs=%b rgb=%h fc=%0d",
               v.name, c, o_rd, o_newline, o_newframe, o_de, o_hsync, o_vsync, o_rgb, o_frame_cnt,
               v.rd, v.nl, v.nf, v.de, v.hs, v.vs, v.rgb, v.fc);
    end else begin
      $display("vec %s c=%0d ok rgb=%h fc=%0d", v.name, c, o_rgb, o_frame_cnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    c++;
    if (o_newline && o_newframe) n_both++;
    if (c >= 122 && c <= 241) begin
      n_rd += int'(o_rd);
      n_nl += int'(o_newline);
      n_nf += int'(o_newframe);
      n_hs += int'(!o_hsync);
      n_vs += int'(!o_vsync);
    end
  endtask

  initial begin
    //   name          cyc rd nl nf de hs vs rgb          fc
    add("reset",        0, 0, 0, 0, 0, 1, 1, 24'h000000, 0);
    add("arm",          1, 0, 0, 0, 0, 1, 1, 24'h000000, 0);
    add("first_run",    2, 1, 0, 1, 0, 1, 1, 24'h000000, 0);
    add("run_h1",       3, 1, 0, 0, 0, 1, 1, 24'h000000, 0);
    add("pre_de",       4, 1, 0, 0, 0, 1, 1, 24'h000000, 0);
    add("first_pix",    5, 1, 0, 0, 1, 1, 1, 24'h00005A, 0);
    add("second_pix",   6, 1, 0, 0, 1, 1, 1, 24'h01005A, 0);
    add("rd_last",      9, 1, 0, 0, 1, 1, 1, 24'h04005A, 0);
    add("rd_drop",     10, 0, 0, 0, 1, 1, 1, 24'h05005A, 0);
    add("last_pix",    12, 0, 0, 0, 1, 1, 1, 24'h07005A, 0);
    add("blank_rgb0",  13, 0, 0, 0, 0, 1, 1, 24'h000000, 0);
    add("hsync_start", 15, 0, 0, 0, 0, 0, 1, 24'h000000, 0);
    add("newline1",    17, 1, 1, 0, 0, 0, 1, 24'h000000, 0);
    add("hsync_end",   18, 1, 0, 0, 0, 1, 1, 24'h000000, 0);
    add("line1_pix",   20, 1, 0, 0, 1, 1, 1, 24'h00015A, 0);
    add("vblank_nl",   62, 0, 1, 0, 0, 0, 1, 24'h000000, 0);
    add("pre_vsync",   79, 0, 0, 0, 0, 1, 1, 24'h000000, 0);
    add("vsync_start", 80, 0, 0, 0, 0, 1, 0, 24'h000000, 0);
    add("vsync_last", 109, 0, 0, 0, 0, 1, 0, 24'h000000, 0);
    add("vsync_end",  110, 0, 0, 0, 0, 1, 1, 24'h000000, 0);
    add("pre_wrap",   121, 0, 0, 0, 0, 0, 1, 24'h000000, 0);
    add("frame_wrap", 122, 1, 0, 1, 0, 0, 1, 24'h000000, 1);
    add("f2_pix0",    125, 1, 0, 0, 1, 1, 1, 24'h00005A, 1);
    add("frame_wrap2",242, 1, 0, 1, 0, 0, 1, 24'h000000, 2);

    i_rst_n   = 1'b0;
    i_src_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    c = 0;

    foreach (tbl[i]) begin
      while (c < tbl[i].cyc) step();
      chk_vec(tbl[i]);
    end

    chk("frame_rd_count",  32'(n_rd), 32'd32);
    chk("frame_nl_count",  32'(n_nl), 32'd7);
    chk("frame_nf_count",  32'(n_nf), 32'd1);
    chk("frame_hs_low",    32'(n_hs), 32'd24);
    chk("frame_vs_low",    32'(n_vs), 32'd30);

    // Source-not-ready pulse mid-line (h=4, v=2 of frame 3).
    while (c < 276) step();
    chk("pre_src_rst_rd", 32'(o_rd), 32'd1);
    i_src_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (o_rd || o_newline || o_newframe) n_hold_strobe++;
    end
    chk("hold_no_strobes", 32'(n_hold_strobe), 32'd0);
    i_src_rst = 1'b0;
    step();
    chk("arm_after_src", {o_rd, o_newframe, o_de, o_hsync, o_vsync, 3'b0, o_rgb}, {8'b0001_1000, 24'h0});
    chk("fc_after_abandon", 32'(o_frame_cnt), 32'd2);
    step();
    chk("nf_after_src", {o_rd, o_newframe}, 2'b11);
    while (c < 400) step();
    chk("fc_pre_wrap3", 32'(o_frame_cnt), 32'd2);
    step();
    chk("fc_wrap3", {o_newframe, o_frame_cnt}, {1'b1, 8'd3});

    // Asynchronous reset mid-active, between clock edges.
    while (c < 406) step();
    chk("pre_arst", {o_rd, o_de, o_rgb}, {2'b11, 24'h02005A});
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_outputs", {o_rd, o_newline, o_newframe, o_de, o_hsync, o_vsync, o_frame_cnt, o_rgb},
        {6'b000011, 8'd0, 24'h0});
    @(negedge clk);
    i_rst_n = 1'b1;
    c = 0;
    step();
    chk("arst_arm", {o_rd, o_newframe}, 2'b00);
    step();
    chk("arst_first_run", {o_rd, o_newframe, o_newline, o_frame_cnt}, {3'b110, 8'd0});

    chk("nl_nf_exclusive", 32'(n_both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_scanout.md
PIXEL_SCANOUT -- requirements
Module: pixel_scanout

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16: horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96: hsync width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 48: horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10: vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2: vsync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33: vertical back porch in lines.
REQ-009 The block SHALL have parameter PIX_LAT, default 1, range 1..4: clocks from o_rd to valid i_pixel.
REQ-010 The block SHALL have parameter SYNC_POL, default 0: sync active level (0 = active-low).
REQ-011 Port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-012 Port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-013 Port i_src_rst, input, 1 bit: pixel-source-not-ready hold, driven from the source's o_rst.
REQ-014 Port i_pixel, input, 24 bits: RGB888 pixel from the source, {R,G,B}.
REQ-015 Port o_rd, output, 1 bit: pixel request, high on every active-region clock.
REQ-016 Port o_newline, output, 1 bit: one-clock start-of-line strobe.
REQ-017 Port o_newframe, output, 1 bit: one-clock start-of-frame strobe.
REQ-018 Port o_hsync, output, 1 bit: horizontal sync, delay-aligned with o_rgb.
REQ-019 Port o_vsync, output, 1 bit: vertical sync, delay-aligned with o_rgb.
REQ-020 Port o_de, output, 1 bit: data enable, delay-aligned with o_rgb.
REQ-021 Port o_rgb, output, 24 bits: captured pixel; zero whenever o_de is low.
REQ-022 Port o_frame_cnt, output, 8 bits: completed-frame counter.

Function
REQ-023 Counters h_cnt and v_cnt SHALL be sized for H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; h_cnt wraps H_TOTAL-1 -> 0 and then advances v_cnt, which wraps V_TOTAL-1 -> 0.
REQ-024 The FSM SHALL have exactly three states: HOLD (counters held at 0, all strobes 0), ARM (one clock, counters still 0) and RUN (counters advance every clock).
REQ-025 HOLD SHALL go to ARM on the first clock with i_src_rst low; ARM SHALL always go to RUN; RUN SHALL go to HOLD on any clock with i_src_rst high.
REQ-026 i_src_rst SHALL be sampled every clock in every state; asserting it mid-frame in RUN abandons the frame and zeroes the counters on the next edge.
REQ-027 The first RUN clock after ARM SHALL be h=0, v=0.
REQ-028 o_rd SHALL be high exactly when state is RUN, h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; it is combinational from the registered counters.
REQ-029 o_newframe SHALL pulse for one clock in RUN at h=0, v=0.
REQ-030 o_newline SHALL pulse for one clock in RUN at h=0 for v=1..V_TOTAL-1.
REQ-031 o_newline and o_newframe SHALL never be high together.
REQ-032 The raw hsync SHALL be active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); the raw vsync SHALL be active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-033 The active level of both syncs SHALL be SYNC_POL; the inactive level SHALL be the complement, including in HOLD.
REQ-034 The raw de, hsync and vsync (de = o_rd) SHALL pass through a PIX_LAT-stage shift pipeline; o_rgb SHALL register i_pixel when the de tap at stage PIX_LAT is high, and otherwise load 0, so o_rgb, o_de and both syncs align with one another.
REQ-035 Net latency SHALL be PIX_LAT+1 clocks from o_rd high to the matching o_de/o_rgb.
REQ-036 o_frame_cnt SHALL increment, mod 256, on the clock where RUN wraps v_cnt from V_TOTAL-1 to 0; abandoned frames SHALL NOT count.

Reset
REQ-037 While i_rst_n is low, the block SHALL be in state HOLD with h_cnt, v_cnt and o_frame_cnt at 0, all pipeline stages cleared (de 0, syncs inactive), o_rgb 0, and o_rd, o_newline and o_newframe at 0.
REQ-038 Reset SHALL assert asynchronously and release synchronously to clk; after release the block behaves as HOLD and follows REQ-025.

Verification
REQ-039 Reset released with i_src_rst=0 -> o_newframe high on the 2nd clock after release (HOLD->ARM->RUN); o_rd is high for 640 clocks, low for 160; first o_newline is 800 clocks after o_newframe.
REQ-040 Count over one full frame -> exactly 307200 o_rd clocks, 524 o_newline pulses, 1 o_newframe pulse; o_frame_cnt goes 0 -> 1 at the frame wrap.
REQ-041 PIX_LAT=1, source returns i_pixel = {h[7:0], v[7:0], 8'h5A} one clock after o_rd -> o_de rises 2 clocks after o_rd; first o_rgb = 24'h00005A; o_rgb is 0 in blanking.
REQ-042 hsync check, SYNC_POL=0 -> o_hsync low for exactly 96 clocks, starting 656+PIX_LAT+1 clocks after each line start; o_vsync low for exactly 1600 clocks (2 lines) per frame.
REQ-043 i_src_rst pulsed high for 3 clocks mid-line 100 -> o_rd drops next clock; no strobes while held; o_newframe recurs 2 clocks after release; o_frame_cnt unchanged.
REQ-044 i_rst_n asserted asynchronously mid-active -> o_rd, o_de and o_rgb go to 0 and the syncs go inactive without a clock edge; counters read 0 after release.
